// File: rtl/event_led_stretcher.sv
// rtl/event_led_stretcher.sv - turns short event strobes into fixed-length, human-visible LED blinks
// Optional feature macro: STRETCH_RETRIGGER_EN (an edge during ON extends the blink instead of queueing)
module event_led_stretcher #(
  parameter int HOLD_LIMIT = 250000,
  parameter int GAP_LIMIT  = 125000,
  parameter int PEND_W     = 4
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Event,
  input  logic              i_Clear,
  output logic              o_LED,
  output logic              o_Busy,
  output logic [PEND_W-1:0] o_Pending,
  output logic              o_Overflow
);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_GAP} state_t;

  localparam logic [24:0]       HOLD_LAST = 25'(HOLD_LIMIT - 1);
  localparam logic [24:0]       GAP_LAST  = 25'(GAP_LIMIT - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  state_t            state_q, state_d;
  logic [24:0]       cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              event_dly_q, event_dly_d;

  logic [PEND_W-1:0] pend_base;
  logic              edge_det;
  logic              retrig;
  logic              queue_edge;
  logic              consume;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_q      <= '0;
      ovf_q       <= 1'b0;
      // Starts high so a level already asserted at reset release is not an edge
      event_dly_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      event_dly_q <= event_dly_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    event_dly_d = i_Event;
    edge_det    = i_Event & ~event_dly_q;
    pend_base   = i_Clear ? '0 : pend_q;
    consume     = 1'b0;
    retrig      = 1'b0;
`ifdef STRETCH_RETRIGGER_EN
    retrig      = edge_det && (state_q == ST_ON);
`endif
    queue_edge  = edge_det & ~retrig;

    case (state_q)
      ST_IDLE: begin
        if (pend_base != '0) begin
          consume = 1'b1;
          cnt_d   = '0;
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (retrig) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 25'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          // Chain straight into the next blink so no IDLE cycle separates them
          if (pend_base != '0) begin
            consume = 1'b1;
            state_d = ST_ON;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 25'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    pend_d = pend_base;
    ovf_d  = i_Clear ? 1'b0 : ovf_q;
    if (queue_edge && !consume) begin
      if (pend_base == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_base + PEND_ONE;
      end
    end else if (!queue_edge && consume) begin
      pend_d = pend_base - PEND_ONE;
    end
  end

  assign o_LED      = (state_q == ST_ON);
  assign o_Busy     = (state_q != ST_IDLE) || (pend_q != '0);
  assign o_Pending  = pend_q;
  assign o_Overflow = ovf_q;

endmodule
